// File: rtl/uart_pkg.sv
// Shared UART definitions: baud encoding, divisor helper, receiver FSM states, parity modes.
package uart_pkg;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    localparam logic ParEven = 1'b0;
    localparam logic ParOdd  = 1'b1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;
    localparam logic [2:0] StBreak  = 3'd5;

    typedef logic [1:0] baud_t;

    // Rounded clocks-per-oversample-tick for a given baud code.
    function automatic int unsigned div_for(input logic [1:0] baud_rate,
                                            input int unsigned clk_hz,
                                            input int unsigned oversample);
        int unsigned rate;
        rate = (32'd2400 << baud_rate) * oversample;
        return (clk_hz + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: counts 0..div-1 and pulses tick on the last count.
module uart_rx_tick_gen #(
    parameter int unsigned CntW = 11
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            clr,
    input  logic [CntW-1:0] div,
    output logic            tick
);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == div - CntW'(1));

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 16x oversampled framing FSM with 3-sample majority
// voting, optional parity, and registered byte/error outputs with a one-cycle valid pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [1:0]           baud_rate,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned Div0  = div_for(BAUD_2400, CLK_HZ, OVERSAMPLE);
    localparam int unsigned Div1  = div_for(BAUD_4800, CLK_HZ, OVERSAMPLE);
    localparam int unsigned Div2  = div_for(BAUD_9600, CLK_HZ, OVERSAMPLE);
    localparam int unsigned Div3  = div_for(BAUD_19200, CLK_HZ, OVERSAMPLE);
    localparam int unsigned DivW  = $clog2(Div0 + 1);
    localparam int unsigned SampW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Majority window straddles the bit centre; the decision is taken on the last sample.
    localparam logic [SampW-1:0] SampLo  = SampW'(OVERSAMPLE / 2 - 2);
    localparam logic [SampW-1:0] SampCtr = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] SampHi  = SampW'(OVERSAMPLE / 2);
    localparam logic [BitW-1:0]  LastBit = BitW'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 prev_q;
    logic [2:0]           state_q, state_d;
    baud_t                baud_q, baud_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic [SampW-1:0]     samp_q, samp_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [1:0]           hist_q, hist_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic            rx_line;
    logic            start_edge;
    logic            tick;
    logic            clr;
    logic            mid;
    logic            maj;
    logic [DivW-1:0] div;

    assign rx_line    = sync_q[1];
    assign start_edge = prev_q & ~rx_line;
    assign mid        = tick && (samp_q == SampHi);
    assign maj        = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_line) | (hist_q[0] & rx_line);

    always_comb begin
        case (baud_q)
            BAUD_2400:  div = DivW'(Div0);
            BAUD_4800:  div = DivW'(Div1);
            BAUD_9600:  div = DivW'(Div2);
            default:    div = DivW'(Div3);
        endcase
    end

    uart_rx_tick_gen #(
        .CntW (DivW)
    ) u_tick_gen (
        .clock (clock),
        .rst   (rst),
        .clr   (clr),
        .div   (div),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        samp_d       = samp_q;
        bit_d        = bit_q;
        hist_d       = hist_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        clr          = (state_q == StIdle);

        if (tick) begin
            samp_d = samp_q + SampW'(1);
            if (samp_q == SampLo || samp_q == SampCtr) begin
                hist_d = {hist_q[0], rx_line};
            end
        end

        case (state_q)
            StIdle: begin
            end
            StStart: begin
                if (mid) begin
                    if (maj) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
            end
            StData: begin
                if (mid) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LastBit) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (mid) begin
                    par_bit_d = maj;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (mid) begin
                    rx_data_d    = shift_q;
                    rx_valid_d   = 1'b1;
                    parity_err_d = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);
                    frame_err_d  = ~maj;
                    state_d      = maj ? StIdle : StBreak;
                end
            end
            StBreak: begin
                if (rx_line) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept a start edge on the very cycle IDLE is (re-)entered.
        if (state_d == StIdle && start_edge) begin
            state_d   = StStart;
            samp_d    = '0;
            clr       = 1'b1;
            baud_d    = baud_rate;
            par_en_d  = parity_en;
            par_odd_d = parity_odd ? ParOdd : ParEven;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            state_q      <= StIdle;
            baud_q       <= BAUD_2400;
            par_en_q     <= 1'b0;
            par_odd_q    <= ParEven;
            samp_q       <= '0;
            bit_q        <= '0;
            hist_q       <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_in};
            prev_q       <= rx_line;
            state_q      <= state_d;
            baud_q       <= baud_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            hist_q       <= hist_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced clock so each baud code maps to a small divisor.
module tb_uart_rx;

    // 2.4576 MHz gives divisors 64/32/16/8, i.e. 1024/512/256/128 clocks per bit.
    localparam int unsigned ClkHz = 2_457_600;
    localparam int Bit9600 = 256;

    logic       clock;
    logic       rst;
    logic [1:0] baud_rate;
    logic       parity_en;
    logic       parity_odd;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int         pulses = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;
    logic       prev_valid = 1'b0;
    logic       long_pulse = 1'b0;
    logic [7:0] got_q[$];

    uart_rx #(
        .CLK_HZ     (ClkHz),
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .baud_rate  (baud_rate),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observe output pulses just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (rx_valid) begin
            pulses++;
            last_data = rx_data;
            last_perr = parity_err;
            last_ferr = frame_err;
            got_q.push_back(rx_data);
        end
        if (rx_valid && prev_valid) long_pulse = 1'b1;
        prev_valid = rx_valid;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic val, input int cycles);
        rx_in = val;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] data, input int bc, input logic with_par,
                              input logic par_bit, input logic stop_val, input int stop_cyc);
        drive(1'b0, bc);
        for (int i = 0; i < 8; i++) drive(data[i], bc);
        if (with_par) drive(par_bit, bc);
        drive(stop_val, stop_cyc);
    endtask

    initial begin
        int mark;
        int bc;

        rst        = 1'b1;
        rx_in      = 1'b1;
        baud_rate  = 2'b10;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        repeat (4) @(negedge clock);

        // Reset values
        check8("reset_data", rx_data, 8'h00);
        check1("reset_valid", rx_valid, 1'b0);
        check1("reset_perr", parity_err, 1'b0);
        check1("reset_ferr", frame_err, 1'b0);
        check1("reset_busy", busy, 1'b0);

        // Reset in the middle of a frame aborts it
        drive(1'b0, Bit9600);
        drive(1'b1, Bit9600);
        drive(1'b0, Bit9600);
        check1("midframe_busy", busy, 1'b1);
        rx_in = 1'b1;
        rst   = 1'b1;
        repeat (3) @(negedge clock);
        check1("in_reset_busy", busy, 1'b0);
        rst = 1'b0;
        drive(1'b1, 2 * Bit9600);
        check1("after_reset_busy", busy, 1'b0);
        checkn("after_reset_pulses", pulses, 0);
        check8("after_reset_data", rx_data, 8'h00);
        send_frame(8'h5A, Bit9600, 1'b0, 1'b0, 1'b1, Bit9600);
        checkn("post_reset_pulses", pulses, 1);
        check8("post_reset_data", last_data, 8'h5A);

        // 8N1 at 9600
        mark = pulses;
        send_frame(8'hA5, Bit9600, 1'b0, 1'b0, 1'b1, Bit9600);
        checkn("a5_pulses", pulses - mark, 1);
        check8("a5_data", last_data, 8'hA5);
        check1("a5_perr", last_perr, 1'b0);
        check1("a5_ferr", last_ferr, 1'b0);
        check1("a5_idle_busy", busy, 1'b0);

        // All four rates with alternating +2% / -2% transmitter error
        for (int code = 0; code < 4; code++) begin
            baud_rate = 2'(code);
            bc = 16 * (64 >> code);
            bc = (code % 2 == 0) ? (bc * 102) / 100 : (bc * 98) / 100;
            drive(1'b1, 20);
            mark = pulses;
            send_frame(8'h3C, bc, 1'b0, 1'b0, 1'b1, bc);
            checkn($sformatf("rate%0d_pulses", code), pulses - mark, 1);
            check8($sformatf("rate%0d_data", code), last_data, 8'h3C);
        end

        // baud_rate change mid-frame does not disturb the current frame
        baud_rate = 2'b10;
        drive(1'b1, 20);
        mark = pulses;
        drive(1'b0, Bit9600);
        drive(1'b0, Bit9600);
        drive(1'b0, Bit9600);
        baud_rate = 2'b11;
        drive(1'b1, Bit9600);
        drive(1'b1, Bit9600);
        drive(1'b1, Bit9600);
        drive(1'b1, Bit9600);
        drive(1'b0, Bit9600);
        drive(1'b0, Bit9600);
        drive(1'b1, Bit9600);
        checkn("baudchg_pulses", pulses - mark, 1);
        check8("baudchg_data", last_data, 8'h3C);
        baud_rate = 2'b10;
        drive(1'b1, 20);

        // Even parity, 8'h07 with wrong then correct parity bit
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        mark = pulses;
        send_frame(8'h07, Bit9600, 1'b1, 1'b0, 1'b1, Bit9600);
        checkn("par_bad_pulses", pulses - mark, 1);
        check8("par_bad_data", last_data, 8'h07);
        check1("par_bad_perr", last_perr, 1'b1);
        check1("par_bad_ferr", last_ferr, 1'b0);
        send_frame(8'h07, Bit9600, 1'b1, 1'b1, 1'b1, Bit9600);
        checkn("par_ok_pulses", pulses - mark, 2);
        check1("par_ok_perr", last_perr, 1'b0);
        check1("par_ok_perr_held", parity_err, 1'b0);
        parity_en = 1'b0;
        drive(1'b1, 20);

        // Stop bit held low for three bit times: framing error, then break
        mark = pulses;
        send_frame(8'h55, Bit9600, 1'b0, 1'b0, 1'b0, 3 * Bit9600);
        checkn("brk_pulses", pulses - mark, 1);
        check8("brk_data", last_data, 8'h55);
        check1("brk_ferr", last_ferr, 1'b1);
        check1("brk_ferr_held", frame_err, 1'b1);
        check1("brk_busy", busy, 1'b1);
        drive(1'b1, 20);
        check1("brk_release_busy", busy, 1'b0);
        drive(1'b1, Bit9600);
        checkn("brk_no_extra_pulse", pulses - mark, 1);
        send_frame(8'h12, Bit9600, 1'b0, 1'b0, 1'b1, Bit9600);
        checkn("after_brk_pulses", pulses - mark, 2);
        check8("after_brk_data", last_data, 8'h12);
        check1("after_brk_ferr", last_ferr, 1'b0);

        // Short glitch on the idle line
        mark = pulses;
        drive(1'b0, 4 * 16);
        check1("glitch_busy_rise", busy, 1'b1);
        drive(1'b1, 2 * Bit9600);
        check1("glitch_busy_fall", busy, 1'b0);
        checkn("glitch_pulses", pulses - mark, 0);

        // Back-to-back frames
        mark = pulses;
        send_frame(8'h01, Bit9600, 1'b0, 1'b0, 1'b1, Bit9600);
        send_frame(8'hFE, Bit9600, 1'b0, 1'b0, 1'b1, Bit9600);
        drive(1'b1, Bit9600);
        checkn("b2b_pulses", pulses - mark, 2);
        if (got_q.size() >= 2) begin
            check8("b2b_first", got_q[got_q.size() - 2], 8'h01);
            check8("b2b_second", got_q[got_q.size() - 1], 8'hFE);
        end else begin
            checkn("b2b_queue_depth", got_q.size(), 2);
        end

        check1("valid_single_cycle", long_pulse, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
